// File: rtl/demux_stream_pkg.sv
// Shared constants for the demux_stream block: default sizes, counter width
// and the destination-select encoding.
package demux_stream_pkg;
    localparam int   DEMUX_WIDTH_DEF = 32;
    localparam int   DEMUX_DEPTH_DEF = 4;
    localparam int   CNT_WIDTH       = 16;
    localparam logic PORT0           = 1'b0;
    localparam logic PORT1           = 1'b1;
endpackage

// File: rtl/demux_fifo.sv
// Synchronous FIFO with push/pop, full/empty flags and a registered head entry.
// Storage is not cleared on reset; only pointers and occupancy are.
module demux_fifo
    import demux_stream_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH_DEF,
    parameter int DEPTH = DEMUX_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push && !rst)
            r_mem[r_wptr] <= i_data;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/demux_stream.sv
// One-to-two stream demux: each input word is steered by in_sel into one of two
// independent FIFOs. Optional delivery counters enabled by DEMUX_STREAM_CNT_EN.
module demux_stream
    import demux_stream_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH_DEF,
    parameter int DEPTH = DEMUX_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out0_data,
    output logic                 out0_valid,
    input  logic                 out0_ready,
    output logic [WIDTH-1:0]     out1_data,
    output logic                 out1_valid,
`ifdef DEMUX_STREAM_CNT_EN
    input  logic                 out1_ready,
    output logic [CNT_WIDTH-1:0] cnt0,
    output logic [CNT_WIDTH-1:0] cnt1
`else
    input  logic                 out1_ready
`endif
);
    logic w_full0, w_full1, w_empty0, w_empty1;
    logic w_push0, w_push1, w_pop0, w_pop1;

    // Ready looks only at the selected FIFO's full flag, never at downstream ready.
    assign in_ready   = !rst && ((in_sel == PORT1) ? !w_full1 : !w_full0);
    assign w_push0    = in_valid && in_ready && (in_sel == PORT0);
    assign w_push1    = in_valid && in_ready && (in_sel == PORT1);
    assign out0_valid = !w_empty0;
    assign out1_valid = !w_empty1;
    assign w_pop0     = out0_valid && out0_ready && !rst;
    assign w_pop1     = out1_valid && out1_ready && !rst;

    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk(clk), .rst(rst), .i_push(w_push0), .i_data(in_data), .i_pop(w_pop0),
        .o_full(w_full0), .o_empty(w_empty0), .o_head(out0_data)
    );

    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk(clk), .rst(rst), .i_push(w_push1), .i_data(in_data), .i_pop(w_pop1),
        .o_full(w_full1), .o_empty(w_empty1), .o_head(out1_data)
    );

`ifdef DEMUX_STREAM_CNT_EN
    logic [CNT_WIDTH-1:0] r_cnt0, r_cnt1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_pop0) r_cnt0 <= r_cnt0 + 1'b1;
            if (w_pop1) r_cnt1 <= r_cnt1 + 1'b1;
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
`endif
endmodule

// File: doc/demux_stream.md
DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits of input and both outputs.
REQ-002 Parameter DEPTH, default 4, entries per output FIFO; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_data  input  WIDTH  input word.
REQ-006 in_sel  input  1  destination: 0 selects port 0, 1 selects port 1.
REQ-007 in_valid  input  1  in_data/in_sel valid this cycle.
REQ-008 in_ready  output  1  block accepts the word this cycle.
REQ-009 out0_data, out1_data  output  WIDTH  head word of port 0 / port 1 FIFO.
REQ-010 out0_valid, out1_valid  output  1  corresponding outN_data valid.
REQ-011 out0_ready, out1_ready  input  1  downstream accepts corresponding port word.
REQ-012 cnt0, cnt1  output  16  words delivered on port 0 / port 1 (present only with DEMUX_STREAM_CNT_EN).

Function
REQ-013 Input transfer occurs when in_valid && in_ready at a rising edge; the word is pushed into the FIFO selected by in_sel.
REQ-014 in_ready SHALL equal NOT full of the FIFO selected by in_sel; in_ready SHALL NOT depend combinationally on out0_ready/out1_ready.
REQ-015 Output transfer on port N occurs when outN_valid && outN_ready; the head entry is popped.
REQ-016 outN_valid SHALL equal NOT empty of FIFO N; outN_data SHALL be the FIFO N head, held stable while outN_valid && !outN_ready.
REQ-017 Latency: a word accepted at edge k SHALL appear on its port (outN_valid=1) after edge k when FIFO N was empty; no same-cycle bypass.
REQ-018 Words on each port SHALL leave in acceptance order; ports are independent, and a stalled port SHALL NOT block words destined for the other port.
REQ-019 Simultaneous push and pop on one FIFO SHALL leave its occupancy unchanged, including at occupancy DEPTH-1 and at 1.
REQ-020 Full FIFO (occupancy DEPTH) SHALL deassert in_ready for that sel even if the same port pops this cycle.
REQ-021 Push to the non-selected FIFO SHALL never occur; in_sel is sampled only on transfer cycles.
REQ-022 Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
REQ-023 in_data with in_valid=0 SHALL be ignored regardless of in_sel.

Reset
REQ-024 With rst=1 at an edge, both FIFOs SHALL become empty (pointers and occupancies 0), out0_valid=out1_valid=0, cnt0=cnt1=0.
REQ-025 During reset cycles in_ready SHALL be 0 and no push or pop SHALL occur.
REQ-026 Reset asserted mid-operation SHALL discard all buffered words; the first word after rst deasserts is the first delivered.
REQ-027 outN_data value while outN_valid=0 is don't-care; storage arrays need not be cleared.

Configuration
REQ-028 Macro DEMUX_STREAM_CNT_EN defined: cnt0/cnt1 ports exist, each increments by 1 per output transfer on its port, wraps 0xFFFF->0x0000, cleared by reset.
REQ-029 Macro DEMUX_STREAM_CNT_EN undefined: cnt0/cnt1 ports and counter logic are absent; all other behaviour identical.

Structure
REQ-030 Shared package demux_stream_pkg holds DEMUX_WIDTH_DEF=32, DEMUX_DEPTH_DEF=4, CNT_WIDTH=16, and port-select encoding constants PORT0=0, PORT1=1.
REQ-031 One sub-module, demux_fifo (synchronous FIFO with push/pop/full/empty/head), instantiated twice; top level holds steering and counters only.

Verification
REQ-032 Reset then push 0xA5A5A5A5 sel=0, out0_ready=1 -> out0_valid rises one edge later with 0xA5A5A5A5; out1_valid stays 0.
REQ-033 out1_ready=0, push 5 words sel=1 (DEPTH=4) -> 4 accepted, in_ready=0 on 5th; then out1_ready=1 -> words 1..4 emitted in order, 5th then accepted.
REQ-034 Port 1 full and stalled, push 0x11 sel=0 -> in_ready=1, 0x11 delivered on port 0 while port 1 remains full.
REQ-035 FIFO 0 at occupancy 2, push and pop same cycle -> occupancy stays 2; 16 alternating push/pop cycles exercise pointer wrap with no loss or reorder.
REQ-036 Port 0 holds 3 words, rst=1 one cycle -> out0_valid=0 next cycle; new word 0x7 after reset is the first delivered.
REQ-037 With DEMUX_STREAM_CNT_EN: 65537 port-0 transfers -> cnt0=1, cnt1=0; without the macro the build elaborates with no cnt ports.
